mmuart_rx: RTL and testbench
============================

Name: mmuart_rx

Overview:
- UART receiver; the receive-direction counterpart of the team's mmuart transmitter.
- Line format: 8N1, LSB first, 16x oversampling from a programmable divisor.
- Synchronises uart_rx, checks the start bit, majority-votes each bit, and presents the byte with a valid/ack handshake.
- Reports framing error, break and overrun.
- Sits between the pad and the CSR/bus-facing UART wrapper.

Parameters:
- OVERSAMPLE, 16, ticks per bit. Fixed; the counter width depends on it.
- SYNC_STAGES, 2, flip-flops in the uart_rx synchroniser chain. Must be 2 or more.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- uart_rx  in  1  serial line (asynchronous to sys_clk); idle high.
- divisor  in  16  sys_clk cycles per 1/16 bit.
- rx_data  out  8  last good byte.
- rx_valid  out  1  level; rx_data holds an unconsumed byte.
- rx_ack  in  1  consumer pulse; clears rx_valid.
- rx_done  out  1  one-cycle pulse per good byte.
- rx_frame_err  out  1  one-cycle pulse; stop bit sampled 0.
- rx_break  out  1  one-cycle pulse; all data bits 0 and stop bit 0.
- rx_overrun  out  1  one-cycle pulse; good byte arrived while rx_valid=1 and no rx_ack that cycle.

Behaviour:
- Reset values (async): rx_data=0, rx_valid=0, all pulses=0, state=IDLE, tick counter=0, synchroniser flops=1, vote history=3'b111.
- Tick generator:
  - 16-bit down-counter; tick = (count==0).
  - On a tick, reload divisor-1; otherwise decrement.
  - The first tick occurs in the first cycle after reset release.
  - divisor=0 gives a period of 65536 cycles. No special case.
  - A divisor change takes effect at the next reload.
- Sampling:
  - rxs = synchronised line.
  - On each tick, hist <= {hist[1:0], rxs}.
  - vote = majority(hist[1], hist[0], rxs), evaluated on the tick where cnt16==9. This covers samples at sub-bit 7, 8 and 9.
- cnt16 is a 4-bit counter that wraps modulo 16 and advances only on ticks.
- IDLE: on a tick with rxs==0 -> START, cnt16<=1.
- START: on the vote tick:
  - vote==1 -> IDLE (glitch rejected, no outputs).
  - vote==0 -> DATA, bitcnt<=0.
- DATA:
  - On each vote tick: shreg <= {vote, shreg[7:1]}, bitcnt++.
  - After the 8th bit -> STOP.
- STOP: on the vote tick:
  - vote==1: rx_data<=shreg, rx_done=1, rx_valid<=1. If rx_valid was 1 and rx_ack=0 that cycle, also pulse rx_overrun; the new byte overwrites rx_data. Then -> IDLE. The early return allows resync at mid-stop-bit.
  - vote==0: pulse rx_frame_err, and also rx_break if shreg==0. rx_data and rx_valid are unchanged. Then -> WAIT_HIGH.
- WAIT_HIGH: on a tick with rxs==1 -> IDLE. This prevents a held-low line from re-triggering.
- Pulse timing: every pulse is registered and asserted in the cycle after the STOP vote tick, high for exactly one sys_clk.
- Handshake:
  - rx_ack with rx_valid=1 clears rx_valid next cycle.
  - rx_ack with rx_valid=0 is ignored.
  - rx_ack in the same cycle as a new good byte: rx_valid stays 1, no overrun.
- Latency: start edge to rx_done is about 9.5 bit times, plus 2-3 sys_clk for the synchroniser and register.

Decomposition:
- Package mmuart_pkg:
  - state enum IDLE/START/DATA/STOP/WAIT_HIGH
  - OVERSAMPLE=16
  - VOTE_TICK=4'd9
  - DATA_BITS=4'd8
- Sub-module mmuart_tickgen: divisor counter producing the enable16 tick. It will be reused to retrofit the transmitter.

Test Plan:
- divisor=4; send 0xA5 at 64 clk/bit -> rx_done once, rx_data=0xA5, rx_valid=1; rx_frame_err=rx_break=rx_overrun=0.
- divisor=4; 20-cycle low glitch on idle line -> no outputs; next frame 0x3C received correctly.
- divisor=4; send 0x55 with stop bit forced 0, then line high -> rx_frame_err pulse, rx_break=0, rx_valid unchanged; next 0x81 received.
- divisor=4; hold line low for 12 bit times, then high -> exactly one rx_frame_err and one rx_break; no rx_done; a frame sent afterwards is received.
- divisor=2; send 0x11 then 0x22 without rx_ack -> second frame pulses rx_overrun, rx_data=0x22; repeat with rx_ack coincident with the second rx_done -> no overrun.
- divisor=4; assert sys_rst_n=0 mid-byte (DATA bit 4), release, send 0xF0 -> all outputs at reset values during reset; 0xF0 received cleanly after release.

Source files
------------

// File: rtl/mmuart_pkg.sv
// Shared types and constants for the mmuart receive/transmit blocks.
package mmuart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned CNT16_W    = $clog2(OVERSAMPLE);
    localparam int unsigned DIV_W      = 16;
    localparam int unsigned BYTE_W     = 8;

    localparam logic [CNT16_W-1:0] VOTE_TICK = 4'd9;
    localparam logic [3:0]         DATA_BITS = 4'd8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/mmuart_tickgen.sv
// Divisor down-counter producing the 16x oversampling enable.
module mmuart_tickgen
    import mmuart_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] divisor_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // tick_q mirrors (cnt_q == 0); divisor 0 wraps to a 65536-cycle period.
    always_comb begin
        cnt_d  = (cnt_q == '0) ? (divisor_i - DIV_W'(1)) : (cnt_q - DIV_W'(1));
        tick_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/mmuart_rx.sv
// 8N1 UART receiver: synchroniser, 16x oversampling with 3-sample vote,
// valid/ack byte handshake and framing/break/overrun pulses.
module mmuart_rx
    import mmuart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              uart_rx,
    input  logic [DIV_W-1:0]  divisor,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic              rx_done,
    output logic              rx_frame_err,
    output logic              rx_break,
    output logic              rx_overrun
);

    logic                   tick;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   vote_c;
    logic                   vote_tick_c;

    rx_state_e          state_q, state_d;
    logic [2:0]         hist_q, hist_d;
    logic [CNT16_W-1:0] cnt16_q, cnt16_d;
    logic [3:0]         bitcnt_q, bitcnt_d;
    logic [BYTE_W-1:0]  shreg_q, shreg_d;
    logic [BYTE_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               fe_q, fe_d;
    logic               brk_q, brk_d;
    logic               ovr_q, ovr_d;

    mmuart_tickgen u_tickgen (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .divisor_i (divisor),
        .tick_o    (tick)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) sync_q <= '1;
        else            sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
    end

    assign rxs         = sync_q[SYNC_STAGES-1];
    assign vote_c      = maj3(hist_q[1], hist_q[0], rxs);
    assign vote_tick_c = tick && (cnt16_q == VOTE_TICK);

    always_comb begin
        state_d  = state_q;
        hist_d   = hist_q;
        cnt16_d  = cnt16_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        fe_d     = 1'b0;
        brk_d    = 1'b0;
        ovr_d    = 1'b0;

        if (rx_ack && valid_q) valid_d = 1'b0;

        if (tick) begin
            hist_d  = {hist_q[1:0], rxs};
            cnt16_d = cnt16_q + CNT16_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (tick && !rxs) begin
                    state_d = START;
                    cnt16_d = CNT16_W'(1);
                end
            end
            START: begin
                if (vote_tick_c) begin
                    if (vote_c) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = DATA;
                        bitcnt_d = 4'd0;
                    end
                end
            end
            DATA: begin
                if (vote_tick_c) begin
                    shreg_d  = {vote_c, shreg_q[BYTE_W-1:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == DATA_BITS - 4'd1) state_d = STOP;
                end
            end
            STOP: begin
                // Returning at mid-stop-bit leaves half a bit to resync on the next start edge.
                if (vote_tick_c) begin
                    if (vote_c) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        done_d  = 1'b1;
                        ovr_d   = valid_q && !rx_ack;
                        state_d = IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        brk_d   = (shreg_q == '0);
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (tick && rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= IDLE;
            hist_q   <= 3'b111;
            cnt16_q  <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            fe_q     <= 1'b0;
            brk_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            cnt16_q  <= cnt16_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            fe_q     <= fe_d;
            brk_q    <= brk_d;
            ovr_q    <= ovr_d;
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_done      = done_q;
    assign rx_frame_err = fe_q;
    assign rx_break     = brk_q;
    assign rx_overrun   = ovr_q;

endmodule

// File: tb/tb_mmuart_rx.sv
// Bench for mmuart_rx: directed frames plus random frames, scored against a frame-level model.
module tb_mmuart_rx;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        uart_rx   = 1'b1;
    logic        rx_ack    = 1'b0;
    logic [15:0] divisor   = 16'd4;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_done, rx_frame_err, rx_break, rx_overrun;

    int checks   = 0;
    int failures = 0;

    int n_done = 0, n_fe = 0, n_brk = 0, n_ovr = 0, n_long = 0;
    logic prev_any = 1'b0;

    int         exp_done = 0, exp_fe = 0, exp_brk = 0, exp_ovr = 0;
    logic       exp_valid = 1'b0;
    logic [7:0] exp_data  = 8'h00;

    mmuart_rx #(.SYNC_STAGES(2)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .uart_rx      (uart_rx),
        .divisor      (divisor),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ack       (rx_ack),
        .rx_done      (rx_done),
        .rx_frame_err (rx_frame_err),
        .rx_break     (rx_break),
        .rx_overrun   (rx_overrun)
    );

    always #5 sys_clk = ~sys_clk;

    // Pulse counters; a pulse seen on two consecutive cycles counts as too long.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (rx_done)      n_done++;
            if (rx_frame_err) n_fe++;
            if (rx_break)     n_brk++;
            if (rx_overrun)   n_ovr++;
            if ((rx_done | rx_frame_err | rx_break | rx_overrun) && prev_any) n_long++;
            prev_any = rx_done | rx_frame_err | rx_break | rx_overrun;
        end else begin
            prev_any = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".done"},  32'(n_done), 32'(exp_done));
        chk({tag, ".ferr"},  32'(n_fe),   32'(exp_fe));
        chk({tag, ".break"}, 32'(n_brk),  32'(exp_brk));
        chk({tag, ".ovr"},   32'(n_ovr),  32'(exp_ovr));
        chk({tag, ".valid"}, 32'(rx_valid), 32'(exp_valid));
        chk({tag, ".data"},  32'(rx_data),  32'(exp_data));
        chk({tag, ".width"}, 32'(n_long), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".data"},  32'(rx_data),      32'd0);
        chk({tag, ".valid"}, 32'(rx_valid),     32'd0);
        chk({tag, ".done"},  32'(rx_done),      32'd0);
        chk({tag, ".ferr"},  32'(rx_frame_err), 32'd0);
        chk({tag, ".break"}, 32'(rx_break),     32'd0);
        chk({tag, ".ovr"},   32'(rx_overrun),   32'd0);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic hold_line(input logic v, input int n);
        uart_rx = v;
        wait_cycles(n);
    endtask

    // Serial frame driver; with ack_on_stop, rx_ack is held through the stop bit until rx_done.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic ack_on_stop);
        int bc;
        bc = 16 * int'(divisor);
        hold_line(1'b0, bc);
        for (int i = 0; i < 8; i++) hold_line(d[i], bc);
        uart_rx = stop;
        if (ack_on_stop) rx_ack = 1'b1;
        for (int c = 0; c < bc; c++) begin
            @(posedge sys_clk);
            #1;
            if (rx_ack && rx_done) rx_ack = 1'b0;
        end
        rx_ack = 1'b0;
        hold_line(1'b1, bc);
    endtask

    // Frame-level expectation: good stop delivers the byte, bad stop flags framing/break.
    task automatic model_frame(input logic [7:0] d, input logic stop);
        if (stop) begin
            if (exp_valid) exp_ovr++;
            exp_done++;
            exp_data  = d;
            exp_valid = 1'b1;
        end else begin
            exp_fe++;
            if (d == 8'h00) exp_brk++;
        end
    endtask

    task automatic tx(input logic [7:0] d, input logic stop, input logic ack_on_stop);
        if (ack_on_stop) exp_valid = 1'b0;
        send_frame(d, stop, ack_on_stop);
        model_frame(d, stop);
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        wait_cycles(1);
        rx_ack = 1'b0;
        exp_valid = 1'b0;
        wait_cycles(1);
    endtask

    initial begin
        logic [7:0] partial;
        logic [7:0] rd;
        logic       rstop;

        #2 sys_rst_n = 1'b0;
        wait_cycles(3);
        check_reset_outputs("reset0");
        sys_rst_n = 1'b1;
        hold_line(1'b1, 64);
        check_all("idle0");

        divisor = 16'd4;
        tx(8'hA5, 1'b1, 1'b0);
        check_all("byte_a5");

        hold_line(1'b0, 20);
        hold_line(1'b1, 128);
        check_all("glitch");
        tx(8'h3C, 1'b1, 1'b0);
        check_all("byte_3c");

        tx(8'h55, 1'b0, 1'b0);
        check_all("frame_err_55");
        tx(8'h81, 1'b1, 1'b0);
        check_all("byte_81");

        hold_line(1'b0, 12 * 64);
        hold_line(1'b1, 64);
        model_frame(8'h00, 1'b0);
        check_all("break");
        tx(8'h7E, 1'b1, 1'b0);
        check_all("after_break");

        divisor = 16'd2;
        do_ack();
        hold_line(1'b1, 64);
        tx(8'h11, 1'b1, 1'b0);
        tx(8'h22, 1'b1, 1'b0);
        check_all("overrun");
        do_ack();
        tx(8'h11, 1'b1, 1'b0);
        tx(8'h22, 1'b1, 1'b1);
        check_all("ack_coincident");

        divisor = 16'd4;
        hold_line(1'b1, 64);
        partial = 8'h5A;
        hold_line(1'b0, 64);
        for (int i = 0; i < 4; i++) hold_line(partial[i], 64);
        hold_line(partial[4], 32);
        sys_rst_n = 1'b0;
        uart_rx   = 1'b1;
        wait_cycles(2);
        check_reset_outputs("reset_mid");
        exp_valid = 1'b0;
        exp_data  = 8'h00;
        sys_rst_n = 1'b1;
        hold_line(1'b1, 128);
        tx(8'hF0, 1'b1, 1'b0);
        check_all("byte_f0");

        for (int k = 0; k < 8; k++) begin
            divisor = 16'(2 + ($urandom % 4));
            hold_line(1'b1, 64);
            if (($urandom % 2) == 0) do_ack();
            rd    = 8'($urandom);
            rstop = (($urandom % 4) != 0);
            tx(rd, rstop, 1'b0);
            check_all($sformatf("rand%0d", k));
        end

        hold_line(1'b1, 64);
        check_all("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
